// File: rtl/arb_pkg.sv
// Shared constants and FSM state encoding for the round-robin / fixed
// priority arbiter.
package arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage : arb_pkg

// File: rtl/prio_enc_n.sv
// Combinational highest-set-bit encoder: idx is the highest index with req
// set, any flags a non-empty request; idx is zero when req is empty.
module prio_enc_n #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         any
);

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      idx = {W{1'b0}};
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = req[i] ? W'(i) : idx;
         any = any | req[i];
      end
   end

endmodule : prio_enc_n

// File: rtl/rr_priority_arbiter.sv
// N-input arbiter with fixed (highest index wins) or round-robin priority,
// presenting a registered, sticky grant over a valid/ready handshake.
module rr_priority_arbiter
   import arb_pkg::*;
#(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         grant_ready,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_onehot,
   output logic [W-1:0] last_idx
);

   state_t       state_r, state_next_s;
   logic [W-1:0] grant_idx_r, grant_idx_next_s;
   logic [N-1:0] grant_onehot_r, grant_onehot_next_s;
   logic [W-1:0] last_idx_r, last_idx_next_s;

   logic         accept_s;
   logic [W-1:0] base_s;
   logic [N-1:0] mask_s;
   logic [N-1:0] masked_req_s;
   logic [W-1:0] masked_idx_s, full_idx_s, winner_s;
   logic         masked_any_s, full_any_s;
   logic [N-1:0] one_s;

   assign one_s = {{(N-1){1'b0}}, 1'b1};

   // On an accept the search base is the index being accepted this edge.
   always_comb begin
      accept_s = (state_r == HOLD) & grant_ready;
      base_s   = accept_s ? grant_idx_r : last_idx_r;
   end

   // Mask keeps only indices strictly below the base (the ones searched first).
   always_comb begin
      mask_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         mask_s[i] = (i < int'(base_s));
      end
      masked_req_s = req & mask_s;
   end

   prio_enc_n #(.N(N), .W(W)) u_enc_masked (
      .req (masked_req_s),
      .idx (masked_idx_s),
      .any (masked_any_s)
   );

   prio_enc_n #(.N(N), .W(W)) u_enc_full (
      .req (req),
      .idx (full_idx_s),
      .any (full_any_s)
   );

   // Winner selection: round-robin falls back to the unmasked search on wrap.
   always_comb begin
      if ((mode == MODE_RR) && masked_any_s) begin
         winner_s = masked_idx_s;
      end else begin
         winner_s = full_idx_s;
      end
   end

   // Next-state and next-output logic for the IDLE/HOLD handshake FSM.
   always_comb begin
      state_next_s        = state_r;
      grant_idx_next_s    = grant_idx_r;
      grant_onehot_next_s = grant_onehot_r;
      last_idx_next_s     = last_idx_r;
      case (state_r)
         IDLE: begin
            if (full_any_s) begin
               state_next_s        = HOLD;
               grant_idx_next_s    = winner_s;
               grant_onehot_next_s = one_s << winner_s;
            end else begin
               state_next_s        = IDLE;
               grant_idx_next_s    = {W{1'b0}};
               grant_onehot_next_s = {N{1'b0}};
            end
         end
         HOLD: begin
            if (accept_s) begin
               last_idx_next_s = grant_idx_r;
               if (full_any_s) begin
                  state_next_s        = HOLD;
                  grant_idx_next_s    = winner_s;
                  grant_onehot_next_s = one_s << winner_s;
               end else begin
                  state_next_s        = IDLE;
                  grant_idx_next_s    = {W{1'b0}};
                  grant_onehot_next_s = {N{1'b0}};
               end
            end else begin
               state_next_s = HOLD;
            end
         end
         default: begin
            state_next_s        = IDLE;
            grant_idx_next_s    = {W{1'b0}};
            grant_onehot_next_s = {N{1'b0}};
            last_idx_next_s     = {W{1'b0}};
         end
      endcase
   end

   // State and output registers; reset drops any pending grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         grant_idx_r    <= {W{1'b0}};
         grant_onehot_r <= {N{1'b0}};
         last_idx_r     <= {W{1'b0}};
      end else begin
         state_r        <= state_next_s;
         grant_idx_r    <= grant_idx_next_s;
         grant_onehot_r <= grant_onehot_next_s;
         last_idx_r     <= last_idx_next_s;
      end
   end

   assign grant_valid  = (state_r == HOLD);
   assign grant_idx    = grant_idx_r;
   assign grant_onehot = grant_onehot_r;
   assign last_idx     = last_idx_r;

endmodule : rr_priority_arbiter

// File: tb/tb_rr_priority_arbiter.sv
// Directed self-checking bench for rr_priority_arbiter (N = 8 and N = 5).
module tb_rr_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic [7:0] req8 = 8'h00;
   logic       mode8 = 1'b0;
   logic       ready8 = 1'b0;
   logic       valid8;
   logic [2:0] idx8;
   logic [7:0] oh8;
   logic [2:0] last8;

   logic [4:0] req5 = 5'b00000;
   logic       mode5 = 1'b0;
   logic       ready5 = 1'b0;
   logic       valid5;
   logic [2:0] idx5;
   logic [4:0] oh5;
   logic [2:0] last5;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rr_priority_arbiter #(.N(8)) u_dut8 (
      .clk          (clk),
      .rst          (rst),
      .req          (req8),
      .mode         (mode8),
      .grant_ready  (ready8),
      .grant_valid  (valid8),
      .grant_idx    (idx8),
      .grant_onehot (oh8),
      .last_idx     (last8)
   );

   rr_priority_arbiter #(.N(5)) u_dut5 (
      .clk          (clk),
      .rst          (rst),
      .req          (req5),
      .mode         (mode5),
      .grant_ready  (ready5),
      .grant_valid  (valid5),
      .grant_idx    (idx5),
      .grant_onehot (oh5),
      .last_idx     (last5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic v, input int i, input int l);
      logic [7:0] oh_exp;
      oh_exp = v ? (8'h01 << i) : 8'h00;
      chk({tag, ".valid"}, 32'(valid8), 32'(v));
      chk({tag, ".idx"}, 32'(idx8), 32'(i));
      chk({tag, ".onehot"}, 32'(oh8), 32'(oh_exp));
      chk({tag, ".last"}, 32'(last8), 32'(l));
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk8("reset", 1'b0, 0, 0);
      chk({"reset5", ".valid"}, 32'(valid5), 32'd0);

      // Fixed mode, sticky grant held while req[5] drops and mode flips
      mode8 = 1'b0; req8 = 8'b0010_0110; ready8 = 1'b0;
      tick();
      chk8("fixed_first", 1'b1, 5, 0);
      req8 = 8'b0000_0110; mode8 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk8("fixed_hold", 1'b1, 5, 0);
      end

      // Fixed mode, all requesting, continuous ready: 7 every cycle
      mode8 = 1'b0; req8 = 8'hFF; ready8 = 1'b1;
      tick();
      chk8("fixed_ff_a", 1'b1, 7, 5);
      tick();
      chk8("fixed_ff_b", 1'b1, 7, 7);
      tick();
      chk8("fixed_ff_c", 1'b1, 7, 7);

      // Round-robin from a fresh reset: 7,6,...,0,7
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mode8 = 1'b1; req8 = 8'hFF; ready8 = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk8("rr_seq", 1'b1, (15 - k) % 8, (k == 0) ? 0 : (16 - k) % 8);
      end

      // Walk down to grant 2, then wrap past 0
      for (int k = 0; k < 5; k++) begin
         tick();
         chk8("rr_walk", 1'b1, 6 - k, (k == 0) ? 7 : 7 - k);
      end
      req8 = 8'b1000_0100;
      tick();
      chk8("rr_wrap", 1'b1, 7, 2);
      tick();
      chk8("rr_after_wrap", 1'b1, 2, 7);

      // Empty request after accept -> IDLE; ready in IDLE ignored
      req8 = 8'h00;
      tick();
      chk8("rr_idle", 1'b0, 0, 2);
      tick();
      chk8("rr_idle_ready", 1'b0, 0, 2);
      req8 = 8'h01;
      tick();
      chk8("rr_req0", 1'b1, 0, 2);

      // Reset mid-handshake wins
      req8 = 8'hFF; ready8 = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; ready8 = 1'b0;
      chk8("rst_hold", 1'b0, 0, 0);
      tick();
      chk8("rst_rearb", 1'b1, 7, 0);

      // N = 5 round-robin: 4,0,4
      mode5 = 1'b1; req5 = 5'b10001; ready5 = 1'b1;
      tick();
      chk("n5_a.idx", 32'(idx5), 32'd4);
      chk("n5_a.onehot", 32'(oh5), 32'h10);
      tick();
      chk("n5_b.idx", 32'(idx5), 32'd0);
      chk("n5_b.last", 32'(last5), 32'd4);
      tick();
      chk("n5_c.idx", 32'(idx5), 32'd4);
      chk("n5_c.last", 32'(last5), 32'd0);
      chk("n5_c.valid", 32'(valid5), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_rr_priority_arbiter

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Parametrised N-input arbiter, generalising the 8-to-3 combinational priority encoder.
- Two modes:
  - fixed priority, with the highest index winning;
  - round-robin, descending from the last granted index.
- Grant is registered and held on a valid/ready handshake toward a single shared resource.
- Used wherever multiple requesters contend for one downstream port.

Parameters:
- N, 8, number of request inputs (N >= 2).
- W, $clog2(N), width of the encoded grant index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high = requester i wants service.
- mode  input  1  0 = fixed priority (index N-1 highest), 1 = round-robin.
- grant_ready  input  1  downstream accepts current grant this cycle.
- grant_valid  output  1  a grant is presented (the old "valid", now registered).
- grant_idx  output  W  encoded index of granted requester.
- grant_onehot  output  N  one-hot form of grant_idx; all zeros when grant_valid = 0.
- last_idx  output  W  index of the most recently accepted grant (round-robin pointer).

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, sampled on the rising clk edge.
- Reset values: grant_valid = 0, grant_idx = 0, grant_onehot = 0, last_idx = 0. Reset wins over every other event in the same cycle, including mid-handshake; the pending grant is dropped.
- States: IDLE (grant_valid = 0) and HOLD (grant_valid = 1).
- IDLE:
  - Arbitrate on req every cycle.
  - If req != 0, load the winner and go to HOLD at the next edge. Latency is 1 cycle from req to grant_valid.
  - If req == 0, stay in IDLE; outputs stay zero except last_idx.
- HOLD:
  - grant_idx and grant_onehot are frozen until grant_valid && grant_ready.
  - Deassertion of the granted req bit does not withdraw the grant (sticky grant).
  - Changes to mode or to other req bits have no effect until acceptance.
- Accept (grant_valid && grant_ready): last_idx <= grant_idx. In the same edge, re-arbitrate on the current req:
  - winner found: stay in HOLD with the new grant (back-to-back, no bubble);
  - req == 0: go to IDLE.
  - The round-robin search in this cycle uses the updated pointer (the just-accepted index) as its base.
- grant_ready while grant_valid = 0 is ignored.
- Fixed mode (mode = 0): winner is the highest set index of req, identical to the 8-to-3 casex encoder when N = 8.
- Round-robin mode (mode = 1):
  - Search descends from index (P-1), where P = last_idx, wrapping from 0 to N-1; index P itself has the lowest priority.
  - Implementation: masked request = req & ((1<<P)-1).
    - If the masked request is nonzero, encode it.
    - Otherwise encode the unmasked req.
  - After reset (P = 0) the mask is empty, so the search starts at N-1, matching fixed mode.
- last_idx updates only on accept, in both modes. Switching mode never resets the pointer.
- Width rules: grant_idx is zero-extended from the encoder. grant_onehot = 1 << grant_idx, gated by grant_valid. No X propagation: default branches assign zeros.
- N not a power of two: indices >= N never appear. The wrap goes from 0 to N-1, not to 2^W-1.

Decomposition:
- Package arb_pkg:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants;
  - state enum {IDLE, HOLD}.
- Sub-module prio_enc_n (params N, W):
  - combinational highest-set-bit encoder with outputs idx[W-1:0] and any;
  - instantiated twice, once for the masked request and once for the unmasked request.

Test Plan:
- Reset, then mode = 0, req = 8'b0010_0110, grant_ready = 0 -> after 1 cycle grant_valid = 1, grant_idx = 5, grant_onehot = 8'h20. Held for 10 cycles even after req[5] drops.
- Mode = 0, req = 8'hFF, grant_ready = 1 continuously -> grant_idx = 7 every cycle with no bubble; last_idx = 7.
- Mode = 1, req = 8'hFF, grant_ready = 1 for 9 cycles -> grant_idx sequence 7,6,5,4,3,2,1,0,7.
- Mode = 1, last_idx = 2, req = 8'b1000_0100 -> grant_idx = 7 (wrap past 0). Next accept with the same req -> grant_idx = 2.
- Mode = 1, req = 8'h00 after accept -> grant_valid = 0 next cycle and grant_onehot = 0. Then req = 8'h01 -> grant_idx = 0 one cycle later.
- rst asserted in HOLD with grant_ready = 1 and req = 8'hFF -> next cycle all outputs 0. Re-arbitration starts from index 7. Repeat with N = 5: req = 5'b10001 in mode 1 -> grants 4,0,4.
